// File: rtl/sound_i2s_pkg.sv
// Shared definitions for the I2S receiver and the matching transmitter.
//   SLOT_BITS  : payload bits carried in each word-select slot
//   SLOT_CNT_W : width of a counter that can hold 0..SLOT_BITS
//   channel_t  : slot identity, encoded as the word-select level
package sound_i2s_pkg;

    localparam int SLOT_BITS  = 16;
    localparam int SLOT_CNT_W = $clog2(SLOT_BITS + 1);

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_t;

endpackage

// File: rtl/sound_i2s_rx.sv
// I2S serial audio receiver. Captures 16-bit MSB-first words from each
// word-select slot (standard one-bit delay after the word-select edge) and
// presents a left/right pair once a complete left slot has been followed by
// a complete right slot.
//
// Ports
//   audio_sclk   in   bit clock; all logic on its rising edge
//   reset_n      in   asynchronous active-low reset
//   audio_lrck   in   word select, 0 = left slot, 1 = right slot
//   audio_dac    in   serial data, MSB first
//   audio_l      out  last complete left sample  (CHANNEL_WIDTH bits)
//   audio_r      out  last complete right sample (CHANNEL_WIDTH bits)
//   sample_valid out  one-cycle pulse: audio_l/audio_r were just updated
//                     together; there is no back-pressure, a consumer must
//                     take the pair on the pulse or read the held values later
//   frame_err    out  one-cycle pulse: a slot ended with fewer than 16 bits
//   locked       out  high once the first word-select edge has been seen
module sound_i2s_rx #(
    parameter int CHANNEL_WIDTH = 16,
    parameter int SIGNED_OUTPUT = 0
) (
    input  logic                     audio_sclk,
    input  logic                     reset_n,
    input  logic                     audio_lrck,
    input  logic                     audio_dac,
    output logic [CHANNEL_WIDTH-1:0] audio_l,
    output logic [CHANNEL_WIDTH-1:0] audio_r,
    output logic                     sample_valid,
    output logic                     frame_err,
    output logic                     locked
);

    import sound_i2s_pkg::*;

    if (CHANNEL_WIDTH < 1 || CHANNEL_WIDTH > SLOT_BITS) begin : g_bad_width
        $error("sound_i2s_rx: CHANNEL_WIDTH must be in 1..16");
    end
    if (SIGNED_OUTPUT != 0 && SIGNED_OUTPUT != 1) begin : g_bad_signed
        $error("sound_i2s_rx: SIGNED_OUTPUT must be 0 or 1");
    end

    localparam logic [SLOT_CNT_W-1:0] CNT_LAST = SLOT_CNT_W'(SLOT_BITS - 1);
    localparam logic [SLOT_CNT_W-1:0] CNT_FULL = SLOT_CNT_W'(SLOT_BITS);

    // Keep the top CHANNEL_WIDTH received bits; offset-binary flips the MSB.
    function automatic logic [CHANNEL_WIDTH-1:0] format_word(input logic [SLOT_BITS-1:0] w);
        logic [CHANNEL_WIDTH-1:0] r;
        r = w[SLOT_BITS-1 -: CHANNEL_WIDTH];
        if (SIGNED_OUTPUT == 0) begin
            r[CHANNEL_WIDTH-1] = ~r[CHANNEL_WIDTH-1];
        end
        return r;
    endfunction

    logic                  lrck_q;
    logic                  primed;     // lrck_q holds a real sample of audio_lrck
    logic [SLOT_CNT_W-1:0] bit_cnt;
    logic [SLOT_BITS-2:0]  shifter;
    logic [SLOT_BITS-1:0]  hold_l;
    logic                  l_done;

    logic                  lrck_edge;
    logic                  take_bit;
    logic                  slot_done;
    logic                  short_slot;
    logic [SLOT_CNT_W-1:0] cnt_next;
    logic [SLOT_BITS-1:0]  word;
    channel_t              chan;

    // The bit sampled on an edge cycle still belongs to the ending slot, so
    // the slot owning the current bit is always the registered word select.
    // Edge detection waits one cycle after reset so that a word select that
    // is already high at release is not mistaken for a slot boundary.
    always_comb begin
        lrck_edge  = primed && (audio_lrck != lrck_q);
        chan       = channel_t'(lrck_q);
        take_bit   = locked && (bit_cnt < CNT_FULL);
        cnt_next   = take_bit ? bit_cnt + 1'b1 : bit_cnt;
        word       = {shifter, audio_dac};
        slot_done  = take_bit && (bit_cnt == CNT_LAST);
        short_slot = locked && lrck_edge && (cnt_next < CNT_FULL);
    end

    always_ff @(posedge audio_sclk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_q       <= 1'b0;
            primed       <= 1'b0;
            bit_cnt      <= '0;
            shifter      <= '0;
            hold_l       <= '0;
            l_done       <= 1'b0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            lrck_q       <= audio_lrck;
            primed       <= 1'b1;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            if (take_bit) begin
                shifter <= word[SLOT_BITS-2:0];
                bit_cnt <= cnt_next;
            end

            if (slot_done) begin
                if (chan == LEFT) begin
                    hold_l <= word;
                    l_done <= 1'b1;
                end else begin
                    if (l_done) begin
                        audio_l      <= format_word(hold_l);
                        audio_r      <= format_word(word);
                        sample_valid <= 1'b1;
                    end
                    l_done <= 1'b0;
                end
            end

            // Slot boundary: restart the count. The slot that was running
            // when lock first occurs was never captured, so it is not judged.
            if (lrck_edge) begin
                bit_cnt <= '0;
                locked  <= 1'b1;
                if (short_slot) begin
                    frame_err    <= 1'b1;
                    sample_valid <= 1'b0;
                    l_done       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_i2s_rx.sv
// Directed bench for sound_i2s_rx: a behavioural I2S transmitter drives two
// receivers (16-bit two's-complement and 8-bit offset-binary) from the same
// serial stream; hand-computed expectations are checked with assertions.
module tb_sound_i2s_rx;

    logic        audio_sclk = 1'b0;
    logic        reset_n;
    logic        audio_lrck;
    logic        audio_dac;

    logic [15:0] audio_l_a, audio_r_a;
    logic        sample_valid_a, frame_err_a, locked_a;
    logic [7:0]  audio_l_b, audio_r_b;
    logic        sample_valid_b, frame_err_b, locked_b;

    sound_i2s_rx #(.CHANNEL_WIDTH(16), .SIGNED_OUTPUT(1)) dut_a (
        .audio_sclk   (audio_sclk),
        .reset_n      (reset_n),
        .audio_lrck   (audio_lrck),
        .audio_dac    (audio_dac),
        .audio_l      (audio_l_a),
        .audio_r      (audio_r_a),
        .sample_valid (sample_valid_a),
        .frame_err    (frame_err_a),
        .locked       (locked_a)
    );

    sound_i2s_rx #(.CHANNEL_WIDTH(8), .SIGNED_OUTPUT(0)) dut_b (
        .audio_sclk   (audio_sclk),
        .reset_n      (reset_n),
        .audio_lrck   (audio_lrck),
        .audio_dac    (audio_dac),
        .audio_l      (audio_l_b),
        .audio_r      (audio_r_b),
        .sample_valid (sample_valid_b),
        .frame_err    (frame_err_b),
        .locked       (locked_b)
    );

    // ---------------- clock ----------------
    always #5 audio_sclk = ~audio_sclk;

    // ---------------- bookkeeping ----------------
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          sv_cnt = 0;
    int          sv_b_cnt = 0;
    int          fe_cnt = 0;
    int          both_cnt = 0;
    int          stab_err = 0;
    int          sv_last = 0;
    int          sv_prev = 0;
    logic [15:0] prev_l = '0;
    logic [15:0] prev_r = '0;
    logic        last_bit = 1'b0;

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge audio_sclk) begin
        cyc++;
        #1;
        if (sample_valid_a) begin
            sv_cnt++;
            sv_prev = sv_last;
            sv_last = cyc;
        end
        if (sample_valid_b) sv_b_cnt++;
        if (frame_err_a) fe_cnt++;
        if (sample_valid_a && frame_err_a) both_cnt++;
        if (reset_n && !sample_valid_a && (audio_l_a !== prev_l || audio_r_a !== prev_r))
            stab_err++;
        prev_l = audio_l_a;
        prev_r = audio_r_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        sv_cnt   = 0;
        sv_b_cnt = 0;
        fe_cnt   = 0;
        both_cnt = 0;
    endtask

    // One word-select slot of len cycles. The first cycle carries the final
    // bit of the previous word (one-bit delay), then word[15] downwards.
    task automatic drive_slot(input logic ch, input logic [15:0] word, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge audio_sclk);
            audio_lrck = ch;
            if (i == 0)       audio_dac = last_bit;
            else if (i <= 16) audio_dac = word[16-i];
            else              audio_dac = 1'b0;
        end
        last_bit = (len <= 16) ? word[16-len] : 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n    = 1'b0;
        audio_lrck = 1'b0;
        audio_dac  = 1'b0;
        repeat (3) @(posedge audio_sclk);
        #1;
        chk("rst_audio_l",   audio_l_a,      16'h0000);
        chk("rst_audio_r",   audio_r_a,      16'h0000);
        chk("rst_valid",     sample_valid_a, 1'b0);
        chk("rst_frame_err", frame_err_a,    1'b0);
        chk("rst_locked",    locked_a,       1'b0);
        chk("rst_b_audio_l", audio_l_b,      8'h00);

        @(negedge audio_sclk);
        reset_n = 1'b1;
        repeat (4) @(negedge audio_sclk);
        chk("idle_locked", locked_a, 1'b0);

        // 32-cycle slots, signed loopback.
        clear_counts();
        drive_slot(1'b1, 16'h0000, 32);
        chk("a_locked", locked_a, 1'b1);
        for (int f = 0; f < 3; f++) begin
            drive_slot(1'b0, 16'h8001, 32);
            drive_slot(1'b1, 16'h7FFE, 32);
        end
        chk("a_valid_cnt", sv_cnt,            32'd3);
        chk("a_interval",  sv_last - sv_prev, 32'd64);
        chk("a_fe_cnt",    fe_cnt,            32'd0);
        chk("a_audio_l",   audio_l_a,         16'h8001);
        chk("a_audio_r",   audio_r_a,         16'h7FFE);
        chk("a_b_audio_l", audio_l_b,         8'h00);
        chk("a_b_audio_r", audio_r_b,         8'hFF);

        // Minimal 16-cycle slots.
        clear_counts();
        for (int f = 0; f < 3; f++) begin
            drive_slot(1'b0, 16'hA5A5, 16);
            drive_slot(1'b1, 16'h5A5A, 16);
        end
        drive_slot(1'b0, 16'hA5A5, 16);
        chk("b_valid_cnt", sv_cnt,            32'd3);
        chk("b_interval",  sv_last - sv_prev, 32'd32);
        chk("b_fe_cnt",    fe_cnt,            32'd0);
        chk("b_audio_l",   audio_l_a,         16'hA5A5);
        chk("b_audio_r",   audio_r_a,         16'h5A5A);
        chk("b_b_audio_l", audio_l_b,         8'h25);
        chk("b_b_audio_r", audio_r_b,         8'hDA);

        // Short left slot, then a clean pair used for the 8-bit check too.
        clear_counts();
        drive_slot(1'b1, 16'h5A5A, 16);
        drive_slot(1'b0, 16'h1111, 12);
        drive_slot(1'b1, 16'h2222, 16);
        chk("c_fe_cnt",       fe_cnt, 32'd1);
        chk("c_valid_before", sv_cnt, 32'd1);
        drive_slot(1'b0, 16'h1234, 16);
        drive_slot(1'b1, 16'hFF00, 16);
        chk("c_no_orphan_r",  sv_cnt, 32'd1);
        drive_slot(1'b0, 16'h0000, 32);
        chk("c_valid_cnt",   sv_cnt,    32'd2);
        chk("c_both",        both_cnt,  32'd0);
        chk("c_audio_l",     audio_l_a, 16'h1234);
        chk("c_audio_r",     audio_r_a, 16'hFF00);
        chk("c_b_audio_l",   audio_l_b, 8'h92);
        chk("c_b_audio_r",   audio_r_b, 8'h7F);
        chk("c_b_valid_cnt", sv_b_cnt,  32'd2);

        // Reset asserted mid-right-slot while a left word is pending.
        drive_slot(1'b1, 16'h7FFE, 10);
        @(negedge audio_sclk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("d_async_l",      audio_l_a,      16'h0000);
        chk("d_async_r",      audio_r_a,      16'h0000);
        chk("d_async_locked", locked_a,       1'b0);
        chk("d_async_valid",  sample_valid_a, 1'b0);
        chk("d_async_b_l",    audio_l_b,      8'h00);
        repeat (3) @(posedge audio_sclk);
        @(negedge audio_sclk);
        reset_n = 1'b1;
        clear_counts();
        drive_slot(1'b1, 16'h7FFE, 8);
        chk("d_not_locked", locked_a, 1'b0);
        drive_slot(1'b0, 16'h1234, 16);
        chk("d_locked",     locked_a, 1'b1);
        drive_slot(1'b1, 16'h5A5A, 16);
        chk("d_no_stale",   sv_cnt,   32'd0);
        drive_slot(1'b0, 16'h0000, 32);
        chk("d_valid_cnt",  sv_cnt,    32'd1);
        chk("d_fe_cnt",     fe_cnt,    32'd0);
        chk("d_audio_l",    audio_l_a, 16'h1234);
        chk("d_audio_r",    audio_r_a, 16'h5A5A);
        chk("d_b_audio_r",  audio_r_b, 8'hDA);
        chk("stable_hold",  stab_err,  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
